// File: rtl/bus_arbiter4_decoded.sv
// Purpose : four-source round-robin bus arbiter driving active-low one-hot selects
//           for a 4x32 decoded buffer mux, with a per-owner hold limit.
// Latency : 1 cycle from a sampled request edge (IDLE) to the winner's select going low.
// Backpressure: none; an owner keeps the bus while requesting, and loses it
//           after MAX_HOLD cycles. Requests not yet granted are not remembered.
//
// Ports:
//   CLK                 rising-edge clock
//   N_RST               asynchronous active-low reset
//   N_REQ_A..N_REQ_D    active-low requests from sources A..D
//   N_SEL_A..N_SEL_D    registered active-low selects, at most one low
//   GRANT_ID[1:0]       registered owner index (0=A..3=D), valid while BUSY=1
//   BUSY                registered, high while any select is low
//   TIMEOUT             registered one-cycle pulse after a forced release
//
// Build option: define ARBITER_TURNAROUND_EN to insert a one-cycle all-deselected
// GAP state after every release (break-before-make). Default build hands over
// directly at the release edge.
module bus_arbiter4_decoded #(
  parameter int unsigned MAX_HOLD = 16  // legal range 2..255
) (
  input  logic       CLK,
  input  logic       N_RST,
  input  logic       N_REQ_A,
  input  logic       N_REQ_B,
  input  logic       N_REQ_C,
  input  logic       N_REQ_D,
  output logic       N_SEL_A,
  output logic       N_SEL_B,
  output logic       N_SEL_C,
  output logic       N_SEL_D,
  output logic [1:0] GRANT_ID,
  output logic       BUSY,
  output logic       TIMEOUT
);

`ifdef ARBITER_TURNAROUND_EN
  localparam bit TURNAROUND = 1'b1;
`else
  localparam bit TURNAROUND = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  hold_q, hold_d;
  logic [1:0]  gid_q, gid_d;
  logic [3:0]  sel_n_q, sel_n_d;
  logic        busy_q, busy_d;
  logic        tmo_q, tmo_d;

  // Active-high request vector, bit index = source index.
  logic [3:0]  req;
  assign req = ~{N_REQ_D, N_REQ_C, N_REQ_B, N_REQ_A};

  // Release detection. A dropped request wins over the hold limit, so a
  // simultaneous drop at HOLD==MAX_HOLD counts as voluntary (no TIMEOUT).
  logic own_req, rel_vol, rel_frc, rel_any;
  assign own_req = req[gid_q];
  assign rel_vol = (state_q == ST_GRANT) && !own_req;
  assign rel_frc = (state_q == ST_GRANT) && own_req && (hold_q == 8'(MAX_HOLD));
  assign rel_any = rel_vol || rel_frc;

  // On a release edge the owner becomes the new LAST, so the scan starts
  // after it; otherwise scan after the stored LAST.
  logic [1:0] scan_base;
  assign scan_base = (state_q == ST_GRANT) ? gid_q : last_q;

  // Cyclic scan from scan_base+1. Walking offsets downwards lets the
  // nearest requester overwrite farther ones; offset 4 (== base itself)
  // has lowest priority, so a lone requester equal to LAST still wins.
  logic       win_vld;
  logic [1:0] win_id;
  logic [1:0] idx;
  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    idx     = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = scan_base + 2'(k);
      if (req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  // Arbitration happens from IDLE/GAP, and also at the release edge itself
  // when there is no turnaround gap.
  logic grant_now;
  assign grant_now = win_vld &&
                     ((state_q != ST_GRANT) || (!TURNAROUND && rel_any));

  // State register.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        state_d = win_vld ? ST_GRANT : ST_IDLE;
      end
      ST_GRANT: begin
        if (rel_any) begin
          if (TURNAROUND) begin
            state_d = ST_GAP;
          end else begin
            state_d = win_vld ? ST_GRANT : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; every visible output is registered.
  always_comb begin
    last_d  = last_q;
    hold_d  = hold_q;
    gid_d   = gid_q;
    sel_n_d = sel_n_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;

    if (rel_any) begin
      last_d  = gid_q;
      tmo_d   = rel_frc;
      sel_n_d = 4'hF;
      busy_d  = 1'b0;
      hold_d  = 8'd0;
    end else if (state_q == ST_GRANT) begin
      hold_d  = hold_q + 8'd1;
    end

    if (grant_now) begin
      gid_d   = win_id;
      sel_n_d = ~(4'b0001 << win_id);
      busy_d  = 1'b1;
      hold_d  = 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      last_q  <= 2'd3;
      hold_q  <= 8'd0;
      gid_q   <= 2'd0;
      sel_n_q <= 4'hF;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      hold_q  <= hold_d;
      gid_q   <= gid_d;
      sel_n_q <= sel_n_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign N_SEL_A  = sel_n_q[0];
  assign N_SEL_B  = sel_n_q[1];
  assign N_SEL_C  = sel_n_q[2];
  assign N_SEL_D  = sel_n_q[3];
  assign GRANT_ID = gid_q;
  assign BUSY     = busy_q;
  assign TIMEOUT  = tmo_q;

endmodule

// File: tb/tb_bus_arbiter4_decoded.sv
// Purpose : directed table vectors, async-reset sequence and a random
//           exclusivity/starvation run for bus_arbiter4_decoded (MAX_HOLD=4).
// Latency : checks outputs 1 time unit after each rising edge.
// Backpressure: n/a (stimulus only).
module tb_bus_arbiter4_decoded;

  localparam int MH = 4;
`ifdef ARBITER_TURNAROUND_EN
  localparam int GAPS = 3;
`else
  localparam int GAPS = 0;
`endif

  logic       clk;
  logic       n_rst;
  logic [3:0] n_req;
  logic       n_sel_a, n_sel_b, n_sel_c, n_sel_d;
  logic [1:0] grant_id;
  logic       busy, timeout;

  int errors = 0;
  int checks = 0;

  bus_arbiter4_decoded #(.MAX_HOLD(MH)) dut (
    .CLK      (clk),
    .N_RST    (n_rst),
    .N_REQ_A  (n_req[0]),
    .N_REQ_B  (n_req[1]),
    .N_REQ_C  (n_req[2]),
    .N_REQ_D  (n_req[3]),
    .N_SEL_A  (n_sel_a),
    .N_SEL_B  (n_sel_b),
    .N_SEL_C  (n_sel_c),
    .N_SEL_D  (n_sel_d),
    .GRANT_ID (grant_id),
    .BUSY     (busy),
    .TIMEOUT  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-high view of the selects, bit i = source i.
  logic [3:0] sel;
  assign sel = ~{n_sel_d, n_sel_c, n_sel_b, n_sel_a};

  typedef struct {
    logic [3:0] req;   // active-high requests, DCBA
    logic [3:0] sel;   // expected active-high selects
    logic [1:0] gid;   // checked only when busy expected
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] r, input logic [3:0] s, input logic [1:0] g,
                     input logic b, input logic t);
    vec_t v;
    v.req = r; v.sel = s; v.gid = g; v.busy = b; v.tmo = t;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] r);
    @(negedge clk);
    n_req = ~r;
    @(posedge clk);
    #1;
  endtask

  int wait_cnt [4];
  int wait_max [4];
  logic [3:0] rreq;

  initial begin
    // Default build expectations (MAX_HOLD=4, reset LAST=3).
`ifndef ARBITER_TURNAROUND_EN
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0); // all request: A first after reset
    add(4'b1011, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0); // A drops: B before D
    add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1100, 4'b1000, 2'd3, 1'b1, 1'b0); // C ignored while D owns
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1); // forced, C regranted, no gap
    add(4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0); // LAST=1: D before A
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1); // forced handover D->A
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0); // drop at limit: voluntary
    add(4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0); // C withdrew before grant
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0); // ... and is not remembered
`else
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b1011, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0); // gap
    add(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0); // B before D
    add(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1); // forced: gap + timeout
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0); // C regranted
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0); // LAST=2: D before A
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1001, 4'b0000, 2'd0, 1'b0, 1'b1);
    add(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0); // C not remembered
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0); // drop at limit: no timeout
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    // Reset with every source requesting: nothing may be selected.
    n_rst = 1'b0;
    n_req = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",  int'(sel),      0);
    chk("rst_busy", int'(busy),     0);
    chk("rst_gid",  int'(grant_id), 0);
    chk("rst_tmo",  int'(timeout),  0);
    @(negedge clk);
    n_req = 4'hF;
    n_rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req);
      chk($sformatf("v%0d_sel", i),  int'(sel),     int'(tbl[i].sel));
      chk($sformatf("v%0d_busy", i), int'(busy),    int'(tbl[i].busy));
      chk($sformatf("v%0d_tmo", i),  int'(timeout), int'(tbl[i].tmo));
      if (tbl[i].busy)
        chk($sformatf("v%0d_gid", i), int'(grant_id), int'(tbl[i].gid));
    end

    // Async reset in the middle of D's grant, between clock edges.
    step(4'b1000);
    step(4'b1000);
    chk("d_owns_sel", int'(sel), 8);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_sel",  int'(sel),      0);
    chk("arst_busy", int'(busy),     0);
    chk("arst_gid",  int'(grant_id), 0);
    chk("arst_tmo",  int'(timeout),  0);
    // Release with all requesting: LAST=3 again, so A wins at the first edge.
    @(negedge clk);
    n_req = 4'h0;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_sel", int'(sel),      1);
    chk("post_rst_gid", int'(grant_id), 0);
    chk("post_rst_busy", int'(busy),    1);

    // Random sticky requests: exclusivity, BUSY/GRANT_ID coherence, fairness.
    rreq = 4'h0;
    for (int i = 0; i < 4; i++) begin
      wait_cnt[i] = 0;
      wait_max[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      chk("onehot", int'($countones(sel) <= 1), 1);
      chk("busy_vs_sel", int'(busy), int'(sel != 4'h0));
      if (sel != 4'h0)
        chk("gid_vs_sel", int'(sel), int'(4'b0001 << grant_id));
      for (int i = 0; i < 4; i++) begin
        if (!n_req[i] && !sel[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > wait_max[i]) wait_max[i] = wait_cnt[i];
        if ($urandom_range(0, 7) == 0) rreq[i] = ~rreq[i];
      end
      n_req = ~rreq;
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("starve_%0d", i), int'(wait_max[i] <= 3 * MH + GAPS), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4_decoded.md
BUS_ARBITER4_DECODED -- requirements
Module: bus_arbiter4_decoded

Interface
REQ-001 Parameter MAX_HOLD, default 16, sets the maximum consecutive grant cycles per owner; legal range is 2..255.
REQ-002 CLK  input  1  is the single clock; all state updates on the rising edge.
REQ-003 N_RST  input  1  is the asynchronous, active-low reset.
REQ-004 N_REQ_A, N_REQ_B, N_REQ_C, N_REQ_D  input  1 each  are active-low bus requests from sources A..D.
REQ-005 N_SEL_A, N_SEL_B, N_SEL_C, N_SEL_D  output  1 each  are registered, active-low, one-hot-or-none bus-drive selects for the 4x32 decoded buffer mux.
REQ-006 GRANT_ID  output  2  is the registered encoded owner (0=A..3=D), valid only while BUSY=1.
REQ-007 BUSY  output  1  is registered high while any N_SEL_* is low.
REQ-008 TIMEOUT  output  1  is a registered one-cycle pulse marking a forced release.

Function
REQ-009 The block SHALL hold FSM states IDLE, GRANT and GAP, a 2-bit last-owner pointer LAST, and an 8-bit hold counter HOLD.
REQ-010 At most one N_SEL_* SHALL be low in any cycle, including during and immediately after reset.
REQ-011 In IDLE, with any N_REQ_* low at an edge, the FSM SHALL select the winner, drive its N_SEL low from the next cycle, set GRANT_ID and BUSY=1, set HOLD=1, and enter GRANT.
REQ-012 The winner SHALL be the first requester found by scanning cyclically from LAST+1 (mod 4).
REQ-013 When the winner is the only requester, it SHALL win even if it equals LAST.
REQ-014 In GRANT, while the owner keeps its N_REQ low and HOLD<MAX_HOLD, the grant SHALL persist and HOLD SHALL increment by 1 per cycle.
REQ-015 A release SHALL occur when the owner's N_REQ is high at an edge (voluntary) or when HOLD==MAX_HOLD (forced).
REQ-016 On a release, LAST SHALL take the owner's index.
REQ-017 On a forced release, TIMEOUT SHALL pulse high for the following cycle.
REQ-018 Requests from non-owners during GRANT SHALL not affect the current grant.
REQ-019 A request deasserted before being granted SHALL be dropped with no memory of it.
REQ-020 Simultaneous voluntary and forced release SHALL be treated as voluntary, with TIMEOUT staying low.
REQ-021 Latency SHALL be exactly 1 cycle from the sampled request edge to N_SEL low when in IDLE.

Reset
REQ-022 While N_RST is low, all N_SEL_* SHALL be 1, BUSY=0, GRANT_ID=0, TIMEOUT=0, HOLD=0, LAST=3 (giving A first priority), and the state SHALL be IDLE, all asynchronously.
REQ-023 Reset asserted mid-grant SHALL release the bus immediately, without waiting for an edge.
REQ-024 After reset deassertion, the first arbitration SHALL follow REQ-011 at the first edge.

Configuration
REQ-025 Macro ARBITER_TURNAROUND_EN SHALL control the break-before-make gap.
REQ-026 With ARBITER_TURNAROUND_EN defined, every release SHALL enter GAP for exactly one cycle with all N_SEL_* high and BUSY=0, then arbitrate as in IDLE, so the next N_SEL goes low 2 cycles after the release edge.
REQ-027 Without ARBITER_TURNAROUND_EN, the release edge SHALL arbitrate directly, so the next winner's N_SEL goes low on the cycle after release with no all-high cycle; the state goes to IDLE if no requests are pending.
REQ-028 In both builds, no cycle SHALL have two N_SEL_* low.

Verification
REQ-029 Reset, then N_REQ_A..D all low at the same edge -> N_SEL_A low the next cycle, GRANT_ID=0, BUSY=1.
REQ-030 A owns the bus, then A releases with B and D requesting -> B granted (LAST=0 scan); GAP cycle present only with macro defined.
REQ-031 MAX_HOLD=4 and C holds N_REQ_C low continuously alone -> N_SEL_C low for 4 cycles, TIMEOUT pulse, then C re-granted (with one all-high cycle if macro defined).
REQ-032 N_RST pulsed low mid-grant of D between clock edges -> N_SEL_D high and BUSY=0 immediately; LAST=3 after reset.
REQ-033 Random request stimulus for 10k cycles, both builds -> never more than one N_SEL_* low, and no requester starved beyond 3*MAX_HOLD(+3 gap cycles) while requesting.
